pipe_delay_line: RTL
====================

PIPE_DELAY_LINE -- requirements
Module: pipe_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 18: data width in bits.
REQ-002 SHALL have parameter MAX_DEPTH, default 4: number of pipeline stages, legal range 1..15.
REQ-003 SHALL have parameter LAT_W, default 3: width of the latency select field, with 2^LAT_W > MAX_DEPTH.
REQ-004 SHALL have parameter INIT_LAT, default 1: latency value loaded at reset, legal range 0..MAX_DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port ce, input, 1 bit: clock enable for the stage chain.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of all stages.
REQ-009 SHALL have port in_data, input, WIDTH bits: input sample.
REQ-010 SHALL have port in_valid, input, 1 bit: input sample qualifier.
REQ-011 SHALL have port lat_sel, input, LAT_W bits: requested latency.
REQ-012 SHALL have port lat_ld, input, 1 bit: load strobe for lat_sel.
REQ-013 SHALL have port out_data, output, WIDTH bits: delayed sample.
REQ-014 SHALL have port out_valid, output, 1 bit: delayed qualifier.
REQ-015 SHALL have port lat_q, output, LAT_W bits: active latency.
REQ-016 SHALL have port lat_err, output, 1 bit: sticky out-of-range flag.

Function
REQ-017 SHALL hold stages S1..S_MAX_DEPTH, each WIDTH data bits plus 1 valid bit.
REQ-018 SHALL, when ce=1 and flush=0 on a rising clk edge, load S1 from {in_data,in_valid} and Sk from Sk-1 for k>1.
REQ-019 SHALL, when ce=0 and flush=0, hold every stage, including the valid bits.
REQ-020 SHALL, when flush=1, clear every stage's data and valid bit to 0 on the next edge, regardless of ce; flush has priority over shifting.
REQ-021 SHALL drive out_data/out_valid combinationally from {in_data,in_valid} when lat_q=0, giving a zero-latency bypass.
REQ-022 SHALL drive out_data/out_valid from stage S[lat_q] when 1<=lat_q<=MAX_DEPTH, giving a latency of lat_q enabled cycles.
REQ-023 SHALL, on an edge with lat_ld=1 and lat_sel<=MAX_DEPTH, set lat_q<=lat_sel; the new tap is seen from the following cycle.
REQ-024 SHALL, on an edge with lat_ld=1 and lat_sel>MAX_DEPTH, set lat_q<=MAX_DEPTH and set lat_err<=1.
REQ-025 SHALL, on lat_ld=1 with a loaded value differing from the current lat_q, clear all stage valid bits on that same edge (implicit flush; data retained); the bypass out_valid stays equal to in_valid.
REQ-026 SHALL ignore stage valid-bit clearing for lat_ld when the loaded value equals the current lat_q.
REQ-027 SHALL keep lat_err set until rst or a lat_ld with an in-range lat_sel, which clears it.
REQ-028 SHALL act on lat_ld independently of ce.
REQ-029 SHALL, when flush, lat_ld and ce are all 1, apply flush and the lat_q update together, with no shift occurring.

Reset
REQ-030 SHALL, while rst=1, immediately force all stage data and valid bits to 0, lat_q=INIT_LAT and lat_err=0, independent of clk.
REQ-031 SHALL give out_data=0 and out_valid=0 during reset when INIT_LAT>0; when INIT_LAT=0, out_data and out_valid follow the inputs.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-033 SHALL cover fill and latency: defaults, lat_q=1, ce=1, in_data=0x00001,0x00002,0x00003 with in_valid=1 -> out_data equals each value exactly 1 cycle later with out_valid=1; then load lat_sel=4 -> the first valid output appears 4 cycles after the load.
REQ-034 SHALL cover the ce stall: lat_q=3, ce dropped for 5 cycles mid-stream -> out_data/out_valid frozen for those cycles, sequence resumes unbroken.
REQ-035 SHALL cover flush under ce: lat_q=2, pipeline full, flush=1 with ce=1 -> next cycle out_valid=0, out_data=0; new input 0x0ABCD appears 2 cycles after flush drops.
REQ-036 SHALL cover bypass and range error: lat_sel=0 load -> out_data==in_data in the same cycle; lat_sel=7 load (MAX_DEPTH=4) -> lat_q=4, lat_err=1; lat_sel=2 load -> lat_err=0.
REQ-037 SHALL cover async reset mid-stream: rst pulsed between clk edges while full -> outputs 0 and lat_q=1 without a clock edge; the stream restarts cleanly.
REQ-038 SHALL cover same-value reload: lat_ld with lat_sel equal to lat_q=3 during streaming -> no valid bubble on out_valid.

Source files
------------

// File: rtl/pipe_delay_line.sv
// Programmable-latency delay line: a chain of MAX_DEPTH data+valid stages with a
// runtime-selectable output tap (0 = combinational bypass) and sticky range error.

module pipe_delay_stage #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             flush,
    input  logic             vclr,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    output logic [WIDTH-1:0] q,
    output logic             qv
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= '0;
            qv <= 1'b0;
        end else if (flush) begin
            q  <= '0;
            qv <= 1'b0;
        end else begin
            if (shift) q <= d;
            // A latency change drops in-flight samples but keeps the data bits.
            qv <= (shift ? dv : qv) & ~vclr;
        end
    end
endmodule

module pipe_delay_line #(
    parameter int WIDTH     = 18,
    parameter int MAX_DEPTH = 4,
    parameter int LAT_W     = 3,
    parameter int INIT_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [LAT_W-1:0] lat_sel,
    input  logic             lat_ld,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [LAT_W-1:0] lat_q,
    output logic             lat_err
);
    localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(MAX_DEPTH);
    localparam logic [LAT_W-1:0] RST_LAT = LAT_W'(INIT_LAT);

    // Index 0 is the live input; index k is stage S_k.
    logic [MAX_DEPTH:0][WIDTH-1:0] data_pipe;
    logic [MAX_DEPTH:0]            vld_pipe;

    logic             lat_oor;
    logic [LAT_W-1:0] lat_new;
    logic             lat_chg;

    assign lat_oor = lat_sel > MAX_LAT;
    assign lat_new = lat_oor ? MAX_LAT : lat_sel;
    assign lat_chg = lat_ld && (lat_new != lat_q);

    assign data_pipe[0] = in_data;
    assign vld_pipe[0]  = in_valid;

    for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
        pipe_delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .shift (ce),
            .flush (flush),
            .vclr  (lat_chg),
            .d     (data_pipe[k-1]),
            .dv    (vld_pipe[k-1]),
            .q     (data_pipe[k]),
            .qv    (vld_pipe[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q   <= RST_LAT;
            lat_err <= 1'b0;
        end else if (lat_ld) begin
            lat_q   <= lat_new;
            lat_err <= lat_oor;
        end
    end

    // lat_q never exceeds MAX_DEPTH, so the bypass default only serves lat_q=0.
    always_comb begin
        out_data  = in_data;
        out_valid = in_valid;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (lat_q == LAT_W'(k)) begin
                out_data  = data_pipe[k];
                out_valid = vld_pipe[k];
            end
        end
    end
endmodule
